// File: rtl/boot_image_loader.sv
// UART boot-image receiver: hunts 0x11 0x55, reads a big-endian 16-bit length and
// packs payload bytes into 32-bit write requests. Optional inter-byte timeout: BOOT_LDR_TIMEOUT_EN.
module boot_image_loader #(
    parameter int                ADDR_W         = 25,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 'h100,
    parameter int                TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_axis_rx_tvalid,
    output logic              s_axis_rx_tready,
    input  logic [7:0]        s_axis_rx_tdata,
    output logic              m_axis_wr_tvalid,
    input  logic              m_axis_wr_tready,
    output logic [ADDR_W-1:0] m_axis_wr_taddr,
    output logic [3:0]        m_axis_wr_tstrb,
    output logic [31:0]       m_axis_wr_tdata,
    input  logic              rearm,
    output logic              busy,
    output logic              done,
    output logic [15:0]       image_len,
    output logic              err
);

    typedef enum logic [2:0] {
        SYNC0, SYNC1, LEN_HI, LEN_LO, PAYLOAD, FLUSH, DONE
    } state_t;

    state_t            state_q;
    logic [15:0]       len_q, remaining_q, offset_q;
    logic [31:0]       pack_data_q, pack_data_d, wr_data_q;
    logic [3:0]        pack_strb_q, pack_strb_d, wr_strb_q;
    logic [ADDR_W-1:0] wr_addr_q, word_addr_d;
    logic              wr_valid_q, busy_q, done_q, err_q;
    logic              rx_fire, wr_fire, word_end_d, timeout_hit;

    // Only a stalled output word can hold off the RX stream, and only while loading payload.
    assign s_axis_rx_tready = !(state_q == PAYLOAD && wr_valid_q && !m_axis_wr_tready);
    assign rx_fire          = s_axis_rx_tvalid && s_axis_rx_tready;
    assign wr_fire          = wr_valid_q && m_axis_wr_tready;

    always_comb begin
        pack_data_d = pack_data_q;
        pack_strb_d = pack_strb_q;
        pack_data_d[{offset_q[1:0], 3'b000} +: 8] = s_axis_rx_tdata;
        pack_strb_d[offset_q[1:0]]                = 1'b1;
    end

    assign word_end_d  = (offset_q[1:0] == 2'd3) || (remaining_q == 16'd1);
    assign word_addr_d = BASE_ADDR + ADDR_W'({offset_q[15:2], 2'b00});

`ifdef BOOT_LDR_TIMEOUT_EN
    localparam int             GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0] gap_q;
    logic             gap_run;

    assign gap_run     = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == PAYLOAD);
    assign timeout_hit = gap_run && !rx_fire && (gap_q == GAP_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gap_q <= '0;
        end else if (!gap_run || rx_fire || timeout_hit) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= SYNC0;
            len_q       <= '0;
            remaining_q <= '0;
            offset_q    <= '0;
            pack_data_q <= '0;
            pack_strb_q <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_valid_q <= 1'b0;
            end
            case (state_q)
                SYNC0: begin
                    if (rx_fire && s_axis_rx_tdata == 8'h11) begin
                        state_q <= SYNC1;
                    end
                end
                SYNC1: begin
                    if (rx_fire) begin
                        if (s_axis_rx_tdata == 8'h55) begin
                            state_q <= LEN_HI;
                            busy_q  <= 1'b1;
                        end else if (s_axis_rx_tdata != 8'h11) begin
                            state_q <= SYNC0;
                        end
                    end
                end
                LEN_HI: begin
                    if (rx_fire) begin
                        len_q[15:8] <= s_axis_rx_tdata;
                        state_q     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (rx_fire) begin
                        len_q[7:0]  <= s_axis_rx_tdata;
                        remaining_q <= {len_q[15:8], s_axis_rx_tdata};
                        offset_q    <= '0;
                        pack_data_q <= '0;
                        pack_strb_q <= '0;
                        if ({len_q[15:8], s_axis_rx_tdata} == 16'd0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_fire) begin
                        offset_q    <= offset_q + 16'd1;
                        remaining_q <= remaining_q - 16'd1;
                        if (word_end_d) begin
                            wr_valid_q  <= 1'b1;
                            wr_addr_q   <= word_addr_d;
                            wr_data_q   <= pack_data_d;
                            wr_strb_q   <= pack_strb_d;
                            pack_data_q <= '0;
                            pack_strb_q <= '0;
                        end else begin
                            pack_data_q <= pack_data_d;
                            pack_strb_q <= pack_strb_d;
                        end
                        if (remaining_q == 16'd1) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (wr_fire) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (rearm) begin
                        state_q <= SYNC0;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= SYNC0;
            endcase
            // A word already presented keeps its valid; only the partial word is dropped.
            if (timeout_hit) begin
                err_q       <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= SYNC0;
                pack_data_q <= '0;
                pack_strb_q <= '0;
            end
        end
    end

    assign m_axis_wr_tvalid = wr_valid_q;
    assign m_axis_wr_taddr  = wr_addr_q;
    assign m_axis_wr_tstrb  = wr_strb_q;
    assign m_axis_wr_tdata  = wr_data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign image_len        = len_q;
    assign err              = err_q;

endmodule

// File: tb/tb_boot_image_loader.sv
// Directed bench for boot_image_loader: frames, junk tolerance, zero length,
// backpressure, reset mid-payload, rearm and (with BOOT_LDR_TIMEOUT_EN) timeout recovery.
`timescale 1ns/1ps
module tb_boot_image_loader;

    localparam int ADDR_W = 25;
`ifdef BOOT_LDR_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 1_000_000;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              rx_tvalid = 1'b0;
    logic [7:0]        rx_tdata = 8'h00;
    logic              wr_tready = 1'b1;
    logic              rearm = 1'b0;
    logic              rx_tready;
    logic              wr_tvalid;
    logic [ADDR_W-1:0] wr_taddr;
    logic [3:0]        wr_tstrb;
    logic [31:0]       wr_tdata;
    logic              busy, done, err;
    logic [15:0]       image_len;

    int checks = 0;
    int errors = 0;
    int stab_errs = 0;
    int base;

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [3:0]        got_strb[$];

    boot_image_loader #(
        .ADDR_W(ADDR_W),
        .BASE_ADDR(25'h100),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .s_axis_rx_tvalid(rx_tvalid),
        .s_axis_rx_tready(rx_tready),
        .s_axis_rx_tdata(rx_tdata),
        .m_axis_wr_tvalid(wr_tvalid),
        .m_axis_wr_tready(wr_tready),
        .m_axis_wr_taddr(wr_taddr),
        .m_axis_wr_tstrb(wr_tstrb),
        .m_axis_wr_tdata(wr_tdata),
        .rearm(rearm),
        .busy(busy),
        .done(done),
        .image_len(image_len),
        .err(err)
    );

    always #5 clk = ~clk;

    // Inputs only change just after a rising edge, so what is seen at the falling
    // edge is exactly what the next rising edge will act on.
    initial begin
        logic              held;
        logic [ADDR_W-1:0] s_addr;
        logic [31:0]       s_data;
        logic [3:0]        s_strb;
        held = 1'b0;
        s_addr = '0;
        s_data = '0;
        s_strb = '0;
        forever begin
            @(negedge clk);
            if (held && (wr_tvalid !== 1'b1 || wr_taddr !== s_addr ||
                         wr_tdata !== s_data || wr_tstrb !== s_strb)) begin
                stab_errs++;
            end
            if (wr_tvalid === 1'b1 && wr_tready) begin
                got_addr.push_back(wr_taddr);
                got_data.push_back(wr_tdata);
                got_strb.push_back(wr_tstrb);
            end
            held   = (wr_tvalid === 1'b1) && !wr_tready;
            s_addr = wr_taddr;
            s_data = wr_tdata;
            s_strb = wr_tstrb;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        rx_tvalid = 1'b1;
        rx_tdata  = b;
        @(negedge clk);
        while (!rx_tready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("rx_accept_timeout", n, 0);
        end
        @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
    endtask

    task automatic send_seq(input logic [127:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, done}, 1);
    endtask

    task automatic pulse_rearm;
        @(posedge clk);
        #1;
        rearm = 1'b1;
        @(posedge clk);
        #1;
        rearm = 1'b0;
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        if (idx < got_data.size()) begin
            chk({tag, "_addr"}, 32'(got_addr[idx]), addr);
            chk({tag, "_data"}, got_data[idx], data);
            chk({tag, "_strb"}, {28'b0, got_strb[idx]}, {28'b0, strb});
        end else begin
            chk({tag, "_missing"}, got_data.size(), idx + 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tready", {31'b0, rx_tready}, 1);
        chk("rst_wvalid", {31'b0, wr_tvalid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_len", {16'b0, image_len}, 0);
        chk("rst_err", {31'b0, err}, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Six-byte image: one full word and a two-byte tail.
        base = got_data.size();
        send_seq(128'h1155, 2);
        @(negedge clk);
        chk("t1_busy", {31'b0, busy}, 1);
        send_seq(128'h0006A1A2A3A4B1B2, 8);
        wait_done("t1_done");
        chk("t1_count", got_data.size(), base + 2);
        chk_word("t1_w0", base, 32'h100, 32'hA4A3A2A1, 4'hF);
        chk_word("t1_w1", base + 1, 32'h104, 32'h0000B2B1, 4'h3);
        chk("t1_len", {16'b0, image_len}, 6);
        chk("t1_busy_end", {31'b0, busy}, 0);
        pulse_rearm();
        @(negedge clk);
        chk("t1_rearm_done", {31'b0, done}, 0);
        chk("t1_rearm_len", {16'b0, image_len}, 6);

        // Junk byte and a repeated 0x11 before the header.
        base = got_data.size();
        send_seq(128'h00111155000_4DEADBEEF, 10);
        wait_done("t2_done");
        chk("t2_count", got_data.size(), base + 1);
        chk_word("t2_w0", base, 32'h100, 32'hEFBEADDE, 4'hF);
        pulse_rearm();

        // Zero length: done the cycle after the length low byte.
        base = got_data.size();
        send_seq(128'h11550000, 4);
        @(negedge clk);
        chk("t3_done", {31'b0, done}, 1);
        chk("t3_len", {16'b0, image_len}, 0);
        repeat (5) @(negedge clk);
        chk("t3_no_write", got_data.size(), base);
        pulse_rearm();

        // Twelve-byte image with the write side stalled for 50 cycles.
        base = got_data.size();
        @(posedge clk);
        #1;
        wr_tready = 1'b0;
        send_seq(128'h1155000C01020304, 8);
        @(negedge clk);
        chk("t4_stall_tready", {31'b0, rx_tready}, 0);
        chk("t4_stall_valid", {31'b0, wr_tvalid}, 1);
        rx_tvalid = 1'b1;
        rx_tdata  = 8'h05;
        repeat (50) @(negedge clk);
        chk("t4_still_stalled", {31'b0, rx_tready}, 0);
        chk("t4_none_yet", got_data.size(), base);
        @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
        wr_tready = 1'b1;
        send_seq(128'h05060708090A0B0C, 8);
        wait_done("t4_done");
        chk("t4_count", got_data.size(), base + 3);
        chk_word("t4_w0", base, 32'h100, 32'h04030201, 4'hF);
        chk_word("t4_w1", base + 1, 32'h104, 32'h08070605, 4'hF);
        chk_word("t4_w2", base + 2, 32'h108, 32'h0C0B0A09, 4'hF);
        chk("t4_len", {16'b0, image_len}, 12);
        pulse_rearm();

        // Reset in the middle of a payload, then a one-byte image, twice.
        base = got_data.size();
        send_seq(128'h1155000801020304_05, 9);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", {31'b0, busy}, 0);
        chk("t5_rst_len", {16'b0, image_len}, 0);
        chk("t5_rst_tready", {31'b0, rx_tready}, 1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        base = got_data.size();
        send_seq(128'h115500017E, 5);
        wait_done("t5_done");
        chk("t5_count", got_data.size(), base + 1);
        chk_word("t5_w0", base, 32'h100, 32'h0000007E, 4'h1);
        pulse_rearm();
        base = got_data.size();
        send_seq(128'h115500017E, 5);
        wait_done("t5b_done");
        chk("t5b_count", got_data.size(), base + 1);
        chk_word("t5b_w0", base, 32'h100, 32'h0000007E, 4'h1);
        pulse_rearm();

`ifdef BOOT_LDR_TIMEOUT_EN
        // Inter-byte gap longer than the timeout, then a clean frame.
        base = got_data.size();
        send_seq(128'h1155000801, 5);
        repeat (150) @(negedge clk);
        chk("t6_err", {31'b0, err}, 1);
        chk("t6_busy", {31'b0, busy}, 0);
        chk("t6_done", {31'b0, done}, 0);
        chk("t6_no_write", got_data.size(), base);
        send_seq(128'h11550004C1C2C3C4, 8);
        wait_done("t6_reload_done");
        chk("t6_count", got_data.size(), base + 1);
        chk_word("t6_w0", base, 32'h100, 32'hC4C3C2C1, 4'hF);
        chk("t6_err_sticky", {31'b0, err}, 1);
`else
        chk("err_tied_low", {31'b0, err}, 0);
`endif

        chk("wr_stable_during_stall", stab_errs, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
